awgn_noise_estimator: RTL
=========================

Name: awgn_noise_estimator

Overview:
Receive-side counterpart of the channel AWGN generator. Hard-slices received 16-QAM I/Q samples (Q1.11) and accumulates squared error vector power over a window of 2^LOG2_WINDOW symbols. Reports mean error power, RMS error and an estimated noise_magnitude code (0..255) on the same scale the generator uses. Sits after the receive matched filter/AGC and feeds the UART/LED status path.

Parameters:
LOG2_WINDOW, 10, log2 of symbols per measurement window (range 4..16).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a measurement window
in_valid  in  1  I/Q sample strobe
in_i  in  12  received I, sample_t Q1.11
in_q  in  12  received Q, sample_t Q1.11
busy  out  1  high from accepted start until result_valid
result_valid  out  1  one-cycle pulse when results update
mse  out  25  mean error power, unsigned Q2.22
rms_err  out  12  isqrt(mse), unsigned Q1.11
mag_est  out  8  estimated generator noise_magnitude
peak_err  out  25  peak per-symbol error power (EVM_PEAK_EN only)

Behaviour:
- Reset: FSM to IDLE; busy=0, result_valid=0, mse=0, rms_err=0, mag_est=0, peak_err=0, counters and accumulator cleared. Reset mid-window abandons the window with no result.
- FSM: IDLE -> ACCUM on start. ACCUM -> DRAIN when the 2^LOG2_WINDOW-th in_valid is accepted. DRAIN lasts 3 cycles. SQRT lasts 13 cycles. SCALE lasts 1 cycle. DONE lasts 1 cycle, pulses result_valid, then returns to IDLE.
- start is ignored outside IDLE. in_valid is ignored outside ACCUM. Gaps in in_valid are allowed; only accepted symbols are counted.
- Slicer, per axis: x < -1295 -> -1943; -1295 <= x < 0 -> -648; 0 <= x < 1295 -> +648; x >= 1295 -> +1943.
- Error e = x - slice, 12-bit signed. |e| <= 648 by construction.
- Pipeline: S1 registers eI/eQ. S2 registers p = eI^2 + eQ^2 (25-bit unsigned). S3 adds p into a (25+LOG2_WINDOW)-bit accumulator.
- mse = acc >> LOG2_WINDOW. Exact shift, no rounding.
- rms_err = floor(sqrt(mse)), computed by the sequential sub-module at 2 radicand bits per cycle (13 iterations).
- mag_est = min(255, (rms_err * 78) >> 8). 78/256 approximates 1/(sqrt(2) * 2048/886.8).
- Latency: result_valid asserts exactly 18 cycles after the cycle that accepts the final symbol. mse, rms_err, mag_est and peak_err update in that same cycle and hold until the next DONE.
- start arriving in the DONE cycle is ignored. A new window requires start in IDLE.

Optional Feature:
- AWGN_EST_PEAK_EN defined: S3 also tracks the maximum p over the window, cleared on accepted start. The result is latched to peak_err at DONE.
- Undefined: peak_err is tied to 0 and no comparator is built.

Decomposition:
- Add to gdsp_pkg:
  - QAM16_LVL_LO=648, QAM16_LVL_HI=1943, QAM16_THR=1295
  - EST_ERRPWR_WIDTH=25
  - EST_MAG_K=78
  - EST_SQRT_ITER=13
  - an est_state_t enum
- Reuse sample_t and NOISE_MAG_WIDTH from the package.
- Sub-module isqrt_seq: start/done handshake, 26-bit radicand in, 13-bit root out, fixed 13-cycle latency.

Test Plan:
- Ideal symbols: 1024 exact constellation points (all 16 cycled) -> mse=0, rms_err=0, mag_est=0, result_valid 18 cycles after the last symbol.
- Constant error, I only: I = slice+100, Q exact, 1024 symbols -> mse=10000, rms_err=100, mag_est=30.
- Constant error, both axes: I and Q both slice+100 -> mse=20000, rms_err=141, mag_est=42.
- Edges: in_i=-2048, in_q=+2047 -> errors -105/+104, p=21841. With AWGN_EST_PEAK_EN, one such symbol among ideal symbols -> peak_err=21841, mse=21841>>10=21.
- Handshake: in_valid at 50% duty with random gaps, plus a start pulse while busy -> exactly 1024 symbols counted, second start ignored, a single result_valid pulse.
- Reset mid-ACCUM after 500 symbols -> all outputs 0 and busy=0 the next cycle; a fresh start then yields a correct result from new symbols only.

Source files
------------

// File: rtl/gdsp_pkg.sv
// Shared DSP types and constants for the channel generator / receive estimator pair.
// Includes the 16-QAM hard slicer used by the AWGN noise estimator.
package gdsp_pkg;

    typedef logic signed [11:0] sample_t;  // Q1.11

    localparam int unsigned NOISE_MAG_WIDTH = 8;

    localparam sample_t QAM16_LVL_LO = 12'sd648;
    localparam sample_t QAM16_LVL_HI = 12'sd1943;
    localparam sample_t QAM16_THR    = 12'sd1295;

    localparam int unsigned EST_ERRPWR_WIDTH = 25;
    localparam int unsigned EST_MAG_K        = 78;
    localparam int unsigned EST_SQRT_ITER    = 13;

    typedef enum logic [2:0] {
        StIdle,
        StAccum,
        StDrain,
        StSqrt,
        StScale,
        StDone
    } est_state_t;

    function automatic sample_t qam16_slice(input sample_t x);
        if (x < -QAM16_THR) begin
            return -QAM16_LVL_HI;
        end else if (x < 12'sd0) begin
            return -QAM16_LVL_LO;
        end else if (x < QAM16_THR) begin
            return QAM16_LVL_LO;
        end else begin
            return QAM16_LVL_HI;
        end
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential integer square root, two radicand bits per cycle.
// Result is ready EST_SQRT_ITER cycles after start_i; done_o pulses for one cycle.
module isqrt_seq
    import gdsp_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [2*EST_SQRT_ITER-1:0] radicand_i,
    output logic [EST_SQRT_ITER-1:0]   root_o,
    output logic                       done_o
);

    localparam int unsigned N    = EST_SQRT_ITER;
    localparam int unsigned RadW = 2 * N;
    localparam int unsigned RemW = N + 2;
    localparam int unsigned CntW = $clog2(N);
    localparam logic [CntW-1:0] CntInit = CntW'(N - 1);

    logic [RadW-1:0] rad_q, src_rad;
    logic [RemW-1:0] rem_q, src_rem, rem_d;
    logic [N-1:0]    root_q, src_root, root_d;
    logic [RemW+1:0] rem_t, trial;
    logic [CntW-1:0] cnt_q;
    logic            busy_q, done_q;

    // The start cycle performs the first iteration straight from radicand_i.
    always_comb begin
        src_rad  = busy_q ? rad_q  : radicand_i;
        src_rem  = busy_q ? rem_q  : '0;
        src_root = busy_q ? root_q : '0;
        rem_t    = {src_rem, src_rad[RadW-1 -: 2]};
        trial    = {2'b00, src_root, 2'b01};
        rem_d    = RemW'(rem_t);
        root_d   = N'({src_root, 1'b0});
        if (rem_t >= trial) begin
            rem_d  = RemW'(rem_t - trial);
            root_d = N'({src_root, 1'b1});
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i || busy_q) begin
                rad_q  <= {src_rad[RadW-3:0], 2'b00};
                rem_q  <= rem_d;
                root_q <= root_d;
            end
            if (busy_q) begin
                cnt_q <= cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= CntInit;
            end
        end
    end

    assign root_o = root_q;
    assign done_o = done_q;

endmodule

// File: rtl/awgn_noise_estimator.sv
// Measures 16-QAM error vector power over 2^LOG2_WINDOW symbols; reports MSE, RMS and magnitude.
// Define AWGN_EST_PEAK_EN to also track the peak per-symbol error power.
module awgn_noise_estimator
    import gdsp_pkg::*;
#(
    parameter int unsigned LOG2_WINDOW = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        in_valid_i,
    input  sample_t                     in_i_i,
    input  sample_t                     in_q_i,
    output logic                        busy_o,
    output logic                        result_valid_o,
    output logic [EST_ERRPWR_WIDTH-1:0] mse_o,
    output logic [11:0]                 rms_err_o,
    output logic [NOISE_MAG_WIDTH-1:0]  mag_est_o,
    output logic [EST_ERRPWR_WIDTH-1:0] peak_err_o
);

    localparam int unsigned PW   = EST_ERRPWR_WIDTH;
    localparam int unsigned AccW = PW + LOG2_WINDOW;

    est_state_t               state_q, state_d;
    logic [LOG2_WINDOW-1:0]   sym_cnt_q;
    logic [1:0]               drain_cnt_q;
    sample_t                  e_i_q, e_q_q;
    logic                     s1_vld_q, s2_vld_q;
    logic [PW-1:0]            p_q;
    logic [AccW-1:0]          acc_q;
    logic [PW-1:0]            mse_q;
    logic [11:0]              rms_q;
    logic [NOISE_MAG_WIDTH-1:0] mag_q;

    logic                     start_acc, accept, sqrt_start, sqrt_done;
    logic [EST_SQRT_ITER-1:0] root;
    logic signed [23:0]       sq_i, sq_q;
    logic [PW-1:0]            mse_w;
    logic [11:0]              rms_w, scaled;
    logic [NOISE_MAG_WIDTH-1:0] mag_w;

    assign start_acc = (state_q == StIdle) && start_i;
    assign accept    = (state_q == StAccum) && in_valid_i;

    always_comb begin
        state_d    = state_q;
        sqrt_start = 1'b0;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StAccum;
            StAccum: if (in_valid_i && (&sym_cnt_q)) state_d = StDrain;
            StDrain: begin
                // Last symbol reaches the accumulator by the third drain cycle.
                if (drain_cnt_q == 2'd2) begin
                    state_d    = StSqrt;
                    sqrt_start = 1'b1;
                end
            end
            StSqrt:  if (sqrt_done) state_d = StScale;
            StScale: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        sq_i   = 24'(e_i_q) * 24'(e_i_q);
        sq_q   = 24'(e_q_q) * 24'(e_q_q);
        mse_w  = PW'(acc_q >> LOG2_WINDOW);
        rms_w  = root[EST_SQRT_ITER-1] ? 12'hFFF : root[11:0];
        scaled = 12'((20'(rms_w) * 20'(EST_MAG_K)) >> 8);
        mag_w  = (scaled > 12'd255) ? 8'hFF : scaled[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sym_cnt_q   <= '0;
            drain_cnt_q <= '0;
            e_i_q       <= '0;
            e_q_q       <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
            mse_q       <= '0;
            rms_q       <= '0;
            mag_q       <= '0;
        end else begin
            drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 2'd1 : 2'd0;
            if (start_acc)   sym_cnt_q <= '0;
            else if (accept) sym_cnt_q <= sym_cnt_q + LOG2_WINDOW'(1);
            s1_vld_q <= accept;
            e_i_q    <= in_i_i - qam16_slice(in_i_i);
            e_q_q    <= in_q_i - qam16_slice(in_q_i);
            s2_vld_q <= s1_vld_q;
            p_q      <= PW'($unsigned(sq_i)) + PW'($unsigned(sq_q));
            if (start_acc)     acc_q <= '0;
            else if (s2_vld_q) acc_q <= acc_q + AccW'(p_q);
            if (state_q == StScale) begin
                mse_q <= mse_w;
                rms_q <= rms_w;
                mag_q <= mag_w;
            end
        end
    end

`ifdef AWGN_EST_PEAK_EN
    logic [PW-1:0] peak_acc_q, peak_out_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            peak_acc_q <= '0;
            peak_out_q <= '0;
        end else begin
            if (start_acc)                        peak_acc_q <= '0;
            else if (s2_vld_q && p_q > peak_acc_q) peak_acc_q <= p_q;
            if (state_q == StScale) peak_out_q <= peak_acc_q;
        end
    end

    assign peak_err_o = peak_out_q;
`else
    assign peak_err_o = '0;
`endif

    isqrt_seq u_isqrt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (sqrt_start),
        .radicand_i ({1'b0, mse_w}),
        .root_o     (root),
        .done_o     (sqrt_done)
    );

    assign busy_o         = (state_q != StIdle) && (state_q != StDone);
    assign result_valid_o = (state_q == StDone);
    assign mse_o          = mse_q;
    assign rms_err_o      = rms_q;
    assign mag_est_o      = mag_q;

endmodule
